// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART definitions: frame length, receive state encoding and a clog2 helper
// used by the receive path, the transmitter and the MMIO read-select stage.
package uart_rx_buffer_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [DATA_BITS-1:0] rx_byte_t;

  // Never returns less than 1 so the result is always usable as a vector width.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_fifo.sv
// First-word-fall-through byte FIFO (module rx_fifo) for the UART receive path;
// pointers carry an extra wrap bit so full and empty are told apart.
module rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  import uart_rx_buffer_pkg::*;

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a FWFT byte FIFO with a sticky overrun flag.
// Define UART_RX_FRAMING_CHECK_EN to drop frames whose stop bit samples low.
module uart_rx_buffer #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DEPTH      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       overrun,
  input  logic       overrun_clr
);
  import uart_rx_buffer_pkg::*;

  // state  | meaning
  // IDLE   | line idle, waiting for rx_s low
  // START  | half-bit wait, confirm start bit still low
  // DATA   | sample 8 data bits, one per bit time, LSB first
  // STOP   | wait one bit time, sample stop bit, push byte

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = clog2(SYMBOL_EDGE_TIME);
  localparam int BW               = clog2(DATA_BITS);

  localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  logic          rx_meta;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  rx_byte_t      shift;
  logic          symbol_done;
  logic          start_ok;
  logic          push_req;
  rx_byte_t      fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_FRAMING_CHECK_EN
  // Held after a bad stop bit until the line returns high, so a break cannot retrigger.
  logic break_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      break_wait <= 1'b0;
    end else if (state == ST_STOP && symbol_done && !rx_s) begin
      break_wait <= 1'b1;
    end else if (rx_s) begin
      break_wait <= 1'b0;
    end
  end

  always_comb begin
    symbol_done = (cnt == SYMBOL_LAST);
    start_ok    = !rx_s && !break_wait;
    push_req    = (state == ST_STOP) && symbol_done && rx_s;
  end
`else
  always_comb begin
    symbol_done = (cnt == SYMBOL_LAST);
    start_ok    = !rx_s;
    push_req    = (state == ST_STOP) && symbol_done;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            cnt   <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == SAMPLE_LAST) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (symbol_done) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (symbol_done) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (shift),
    .pop       (data_out_ready),
    .dout      (fifo_dout),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Full implies non-empty, so ready alone decides whether the pop makes room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (push_req && fifo_full && !data_out_ready) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  always_comb begin
    data_out_valid = !fifo_empty;
    data_out       = fifo_empty ? 8'h00 : fifo_dout;
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer at 10 clocks per bit (SAMPLE_TIME 5).
// Expectations for the bad-stop-bit case follow UART_RX_FRAMING_CHECK_EN.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_out_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_buffer #(
    .CLOCK_FREQ (10_000),
    .BAUD_RATE  (1_000),
    .DEPTH      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling clock edge; the stop level is held for stop_cycles, then the line idles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cycles);
    serial_in = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(10);
    end
    serial_in = stop;
    tick(stop_cycles);
    serial_in = 1'b1;
  endtask

  task automatic pop_one();
    data_out_ready = 1'b1;
    tick(1);
    data_out_ready = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_valid", {7'd0, data_out_valid}, 8'h00);
    chk("rst_data", data_out, 8'h00);
    chk("rst_overrun", {7'd0, overrun}, 8'h00);
    rst = 1'b0;
    tick(5);

    // stop sample lands 98 cycles after the start edge is driven
    send_frame(8'hA5, 1'b1, 7);
    chk("a5_valid_before", {7'd0, data_out_valid}, 8'h00);
    tick(1);
    chk("a5_valid_after", {7'd0, data_out_valid}, 8'h01);
    chk("a5_data", data_out, 8'hA5);
    tick(2);
    pop_one();
    chk("a5_pop_valid", {7'd0, data_out_valid}, 8'h00);
    chk("a5_pop_data", data_out, 8'h00);

    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(30);
    chk("false_start_valid", {7'd0, data_out_valid}, 8'h00);

    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 10);
      if (i == 7) chk("fill8_overrun", {7'd0, overrun}, 8'h00);
    end
    chk("ovr_flag", {7'd0, overrun}, 8'h01);
    chk("ovr_valid", {7'd0, data_out_valid}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovr_pop%0d", i), data_out, 8'(i));
      pop_one();
    end
    chk("ovr_drained", {7'd0, data_out_valid}, 8'h00);
    chk("ovr_sticky", {7'd0, overrun}, 8'h01);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    chk("ovr_cleared", {7'd0, overrun}, 8'h00);

    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 10);
    chk("full_head", data_out, 8'h10);
    send_frame(8'h18, 1'b1, 7);
    data_out_ready = 1'b1;
    tick(1);
    data_out_ready = 1'b0;
    chk("pushpop_overrun", {7'd0, overrun}, 8'h00);
    chk("pushpop_head", data_out, 8'h11);
    tick(2);
    // still holding 8 entries, so one more byte must overrun and be dropped
    send_frame(8'h19, 1'b1, 10);
    chk("still_full_overrun", {7'd0, overrun}, 8'h01);
    chk("still_full_head", data_out, 8'h11);

    serial_in = 1'b0;
    tick(10);
    serial_in = 1'b0;
    tick(10);
    serial_in = 1'b0;
    tick(10);
    serial_in = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    chk("midrst_valid", {7'd0, data_out_valid}, 8'h00);
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_overrun", {7'd0, overrun}, 8'h00);
    rst = 1'b0;
    tick(60);
    chk("postrst_idle_valid", {7'd0, data_out_valid}, 8'h00);
    send_frame(8'h7E, 1'b1, 10);
    chk("postrst_data", data_out, 8'h7E);
    pop_one();
    chk("postrst_drained", {7'd0, data_out_valid}, 8'h00);

    send_frame(8'h55, 1'b0, 10);
    tick(20);
`ifdef UART_RX_FRAMING_CHECK_EN
    chk("badstop_valid", {7'd0, data_out_valid}, 8'h00);
    chk("badstop_overrun", {7'd0, overrun}, 8'h00);
    send_frame(8'hC3, 1'b1, 10);
    chk("after_badstop_data", data_out, 8'hC3);
    pop_one();
`else
    chk("badstop_valid", {7'd0, data_out_valid}, 8'h01);
    chk("badstop_data", data_out, 8'h55);
    pop_one();
    chk("badstop_drained", {7'd0, data_out_valid}, 8'h00);
    send_frame(8'hC3, 1'b1, 10);
    chk("after_badstop_data", data_out, 8'hC3);
    pop_one();
`endif
    chk("final_empty", {7'd0, data_out_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
